// File: rtl/mips_mc_ctrl_pkg.sv
// Shared types and constants for the multicycle MIPS main-control FSM.
package mips_ctrl_pkg;

  // State encodings are visible on the debug port, so they are fixed values.
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RTWB   = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

  // True for the opcodes this controller knows how to sequence.
  function automatic logic op_supported(input logic [5:0] op);
    return (op == OP_R) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
  endfunction

endpackage

// File: rtl/mips_mc_ctrl_if.sv
// Controller <-> datapath bundle: opcode and memory handshake in, control lines out.
interface mips_mc_ctrl_if;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       PCWrite;
  logic       PCWriteCond;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       MemtoReg;
  logic       RegDst;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic [1:0] PCSource;

  modport master (
    input  opcode, mem_ready,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
           MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource
  );

  modport slave (
    output opcode, mem_ready,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
           MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource
  );
endinterface

// File: rtl/mips_mc_ctrl_outdec.sv
// Pure state-to-control decoder (Moore table); gating lives in the top level.
module mips_ctrl_outdec
  import mips_ctrl_pkg::*;
(
  input  state_t state_i,
  output ctrl_t  ctrl_o
);

  // Per-state control table; anything not set stays 0.
  always_comb begin
    ctrl_o = '0;
    unique case (state_i)
      S_FETCH: begin
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.ir_write  = 1'b1;
        ctrl_o.pc_write  = 1'b1;
        ctrl_o.alu_src_b = SRCB_FOUR;
      end
      S_DECODE: ctrl_o.alu_src_b = SRCB_IMMSH;
      S_MEMADR, S_ADDIEX: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.iord     = 1'b1;
      end
      S_MEMWB: begin
        ctrl_o.mem_to_reg = 1'b1;
        ctrl_o.reg_write  = 1'b1;
      end
      S_MEMWR: begin
        ctrl_o.mem_write = 1'b1;
        ctrl_o.iord      = 1'b1;
      end
      S_EXEC: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_op    = ALUOP_FUNC;
      end
      S_RTWB: begin
        ctrl_o.reg_dst   = 1'b1;
        ctrl_o.reg_write = 1'b1;
      end
      S_BRANCH: begin
        ctrl_o.alu_src_a     = 1'b1;
        ctrl_o.alu_op        = ALUOP_SUB;
        ctrl_o.pc_write_cond = 1'b1;
        ctrl_o.pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        ctrl_o.pc_write  = 1'b1;
        ctrl_o.pc_source = PCSRC_JUMP;
      end
      S_ADDIWB: ctrl_o.reg_write = 1'b1;
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multicycle MIPS main-control FSM: state register, next-state, halt/wait
// gating and retired-instruction counter.
// Optional build macro MC_CTRL_MEMWAIT_EN: FETCH, MEMRD and MEMWR wait for mem_ready.
module mips_mc_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             halt,
  mips_mc_ctrl_if.master   bus,
  output logic [3:0]       state,
  output logic             instr_done,
  output logic             illegal_op,
  output logic [CNT_W-1:0] instr_count
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mem_ok;
  ctrl_t            ctrl_raw, ctrl;

`ifdef MC_CTRL_MEMWAIT_EN
  assign mem_ok = bus.mem_ready;
`else
  // Without the wait handshake every memory cycle completes immediately.
  logic unused_mem_ready;
  assign unused_mem_ready = bus.mem_ready;
  assign mem_ok           = 1'b1;
`endif

  mips_ctrl_outdec u_outdec (
    .state_i (state_q),
    .ctrl_o  (ctrl_raw)
  );

  // Next-state selection; halt only matters while sitting in FETCH.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH:  if (!halt && mem_ok) state_d = S_DECODE;
      S_DECODE: begin
        unique case (bus.opcode)
          OP_R:         state_d = S_EXEC;
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDIEX;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (mem_ok) state_d = S_MEMWB;
      S_MEMWR:  if (mem_ok) state_d = S_FETCH;
      S_EXEC:   state_d = S_RTWB;
      S_ADDIEX: state_d = S_ADDIWB;
      default:  state_d = S_FETCH;
    endcase
  end

  // Retire flag: final cycle of every completing instruction.
  always_comb begin
    instr_done = 1'b0;
    unique case (state_q)
      S_MEMWB, S_RTWB, S_BRANCH, S_JUMP, S_ADDIWB: instr_done = 1'b1;
      S_MEMWR: instr_done = mem_ok;
      default: instr_done = 1'b0;
    endcase
  end

  assign illegal_op = (state_q == S_DECODE) && !op_supported(bus.opcode);
  assign cnt_d      = instr_done ? cnt_q + 1'b1 : cnt_q;

  // Control-line gating: halt and memory wait in FETCH, all strobes low in reset.
  always_comb begin
    ctrl = ctrl_raw;
    if (state_q == S_FETCH) begin
      if (halt) begin
        ctrl.mem_read = 1'b0;
        ctrl.ir_write = 1'b0;
        ctrl.pc_write = 1'b0;
      end else begin
        ctrl.ir_write = mem_ok;
        ctrl.pc_write = mem_ok;
      end
    end
    if (!rst_n) begin
      ctrl.pc_write      = 1'b0;
      ctrl.pc_write_cond = 1'b0;
      ctrl.ir_write      = 1'b0;
      ctrl.mem_read      = 1'b0;
      ctrl.mem_write     = 1'b0;
      ctrl.reg_write     = 1'b0;
    end
  end

  // State register and retired-instruction counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign state           = state_q;
  assign instr_count     = cnt_q;
  assign bus.PCWrite     = ctrl.pc_write;
  assign bus.PCWriteCond = ctrl.pc_write_cond;
  assign bus.IorD        = ctrl.iord;
  assign bus.MemRead     = ctrl.mem_read;
  assign bus.MemWrite    = ctrl.mem_write;
  assign bus.IRWrite     = ctrl.ir_write;
  assign bus.MemtoReg    = ctrl.mem_to_reg;
  assign bus.RegDst      = ctrl.reg_dst;
  assign bus.RegWrite    = ctrl.reg_write;
  assign bus.ALUSrcA     = ctrl.alu_src_a;
  assign bus.ALUSrcB     = ctrl.alu_src_b;
  assign bus.ALUOp       = ctrl.alu_op;
  assign bus.PCSource    = ctrl.pc_source;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Bench for mips_mc_ctrl: instruction-level reference model (per-opcode state
// paths and the Moore output table) driven with randomized opcodes and mem_ready.
module tb_mips_mc_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       halt;
  logic [3:0] state;
  logic       instr_done;
  logic       illegal_op;
  logic [3:0] instr_count;

  mips_mc_ctrl_if bus ();

  mips_mc_ctrl #(.CNT_W(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .halt        (halt),
    .bus         (bus),
    .state       (state),
    .instr_done  (instr_done),
    .illegal_op  (illegal_op),
    .instr_count (instr_count)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  logic [3:0] model_cnt = 4'd0;
  bit         rand_ready = 1'b0;
  int         memwr_stall = 0;

`ifdef MC_CTRL_MEMWAIT_EN
  localparam bit MEMWAIT = 1'b1;
`else
  localparam bit MEMWAIT = 1'b0;
`endif

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected control lines for a state, straight from the output table.
  function automatic logic [15:0] exp_ctrl(input int st, input bit hlt, input bit mr, input bit rst);
    logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca;
    logic [1:0] srcb, aop, pcs;
    {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca} = '0;
    srcb = 2'b00; aop = 2'b00; pcs = 2'b00;
    case (st)
      0: begin
        srcb = 2'b01;
        mrd  = !hlt;
        irw  = !hlt && (mr || !MEMWAIT);
        pcw  = irw;
      end
      1: srcb = 2'b11;
      2, 10: begin srca = 1'b1; srcb = 2'b10; end
      3: begin mrd = 1'b1; iord = 1'b1; end
      4: begin m2r = 1'b1; rw = 1'b1; end
      5: begin mwr = 1'b1; iord = 1'b1; end
      6: begin srca = 1'b1; aop = 2'b10; end
      7: begin rdst = 1'b1; rw = 1'b1; end
      8: begin srca = 1'b1; aop = 2'b01; pcwc = 1'b1; pcs = 2'b01; end
      9: begin pcw = 1'b1; pcs = 2'b10; end
      11: rw = 1'b1;
      default: ;
    endcase
    if (rst) {pcw, pcwc, irw, mrd, mwr, rw} = '0;
    return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca, srcb, aop, pcs};
  endfunction

  function automatic logic [15:0] obs_ctrl();
    return {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite,
            bus.IRWrite, bus.MemtoReg, bus.RegDst, bus.RegWrite, bus.ALUSrcA,
            bus.ALUSrcB, bus.ALUOp, bus.PCSource};
  endfunction

  // Runs one instruction from its FETCH cycle, checking every cycle; returns cycle count.
  task automatic run_instr(input logic [5:0] op, input bit raise_halt, output int cycles);
    int  path[6];
    int  plen;
    bit  legal;
    int  st;
    int  waits;
    bit  mr;
    bit  adv;
    bit  exp_done;
    legal = 1'b1;
    path[0] = 0; path[1] = 1;
    case (op)
      6'b100011: begin path[2] = 2; path[3] = 3; path[4] = 4; plen = 5; end
      6'b101011: begin path[2] = 2; path[3] = 5; plen = 4; end
      6'b000000: begin path[2] = 6; path[3] = 7; plen = 4; end
      6'b001000: begin path[2] = 10; path[3] = 11; plen = 4; end
      6'b000100: begin path[2] = 8; plen = 3; end
      6'b000010: begin path[2] = 9; plen = 3; end
      default:   begin plen = 2; legal = 1'b0; end
    endcase
    bus.opcode = op;
    cycles = 0;
    for (int i = 0; i < plen; i++) begin
      st = path[i];
      waits = 0;
      do begin
        if (st == 5 && memwr_stall > 0) begin
          mr = 1'b0;
          memwr_stall--;
        end else if (!rand_ready || waits >= 6) begin
          mr = 1'b1;
        end else begin
          mr = 1'($urandom_range(0, 1));
        end
        bus.mem_ready = mr;
        #1;
        adv = !(MEMWAIT && (st == 0 || st == 3 || st == 5)) || mr;
        exp_done = (st == 4 || st == 7 || st == 8 || st == 9 || st == 11) || (st == 5 && adv);
        check_eq($sformatf("state_s%0d", st), 32'(state), 32'(st));
        check_eq($sformatf("ctrl_s%0d", st), 32'(obs_ctrl()), 32'(exp_ctrl(st, 1'b0, mr, 1'b0)));
        check_eq($sformatf("done_s%0d", st), 32'(instr_done), 32'(exp_done));
        check_eq($sformatf("illegal_s%0d", st), 32'(illegal_op), 32'(st == 1 && !legal));
        check_eq("count", 32'(instr_count), 32'(model_cnt));
        if (exp_done) model_cnt = model_cnt + 4'd1;
        cycles++;
        waits++;
        @(negedge clk);
        if (raise_halt && i == 0 && adv) halt = 1'b1;
      end while (!adv);
    end
  endtask

  // Stays parked in FETCH with halt high for n cycles.
  task automatic park(input int n);
    bit mr;
    for (int i = 0; i < n; i++) begin
      mr = 1'($urandom_range(0, 1));
      bus.mem_ready = mr;
      #1;
      check_eq("halt_state", 32'(state), 32'd0);
      check_eq("halt_ctrl", 32'(obs_ctrl()), 32'(exp_ctrl(0, 1'b1, mr, 1'b0)));
      check_eq("halt_done", 32'(instr_done), 32'd0);
      check_eq("halt_count", 32'(instr_count), 32'(model_cnt));
      @(negedge clk);
    end
  endtask

  function automatic logic [5:0] pick_op();
    logic [5:0] o;
    case ($urandom_range(0, 6))
      0: o = 6'b000000;
      1: o = 6'b100011;
      2: o = 6'b101011;
      3: o = 6'b000100;
      4: o = 6'b000010;
      5: o = 6'b001000;
      default: begin
        o = 6'($urandom);
        if (o == 6'b000000 || o == 6'b100011 || o == 6'b101011 ||
            o == 6'b000100 || o == 6'b000010 || o == 6'b001000) o = 6'b111111;
      end
    endcase
    return o;
  endfunction

  initial begin
    int cyc;
    logic [3:0] start_cnt;
    rst_n = 1'b0;
    halt = 1'b0;
    bus.opcode = 6'b000000;
    bus.mem_ready = 1'b1;
    #1;
    check_eq("rst_state", 32'(state), 32'd0);
    check_eq("rst_ctrl", 32'(obs_ctrl()), 32'(exp_ctrl(0, 1'b0, 1'b1, 1'b1)));
    check_eq("rst_count", 32'(instr_count), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed zero-wait latencies.
    run_instr(6'b100011, 1'b0, cyc); check_eq("lat_lw", 32'(cyc), 32'd5);
    run_instr(6'b000000, 1'b0, cyc); check_eq("lat_r", 32'(cyc), 32'd4);
    run_instr(6'b000100, 1'b0, cyc); check_eq("lat_beq", 32'(cyc), 32'd3);
    run_instr(6'b000010, 1'b0, cyc); check_eq("lat_j", 32'(cyc), 32'd3);
    check_eq("count_after_4", 32'(instr_count), 32'(model_cnt));
    run_instr(6'b101011, 1'b0, cyc); check_eq("lat_sw", 32'(cyc), 32'd4);
    run_instr(6'b001000, 1'b0, cyc); check_eq("lat_addi", 32'(cyc), 32'd4);
    run_instr(6'b111111, 1'b0, cyc); check_eq("lat_illegal", 32'(cyc), 32'd2);

    // sw with three stalled MEMWR cycles.
    memwr_stall = 3;
    run_instr(6'b101011, 1'b0, cyc);
    check_eq("lat_sw_stall", 32'(cyc), MEMWAIT ? 32'd7 : 32'd4);
    memwr_stall = 0;

    // Randomized opcode and mem_ready mix.
    rand_ready = 1'b1;
    for (int k = 0; k < 80; k++) run_instr(pick_op(), 1'b0, cyc);

    // Halt raised mid-add: the add completes, then the FSM parks.
    run_instr(6'b000000, 1'b1, cyc);
    park(5);
    halt = 1'b0;

    // Reset while in EXEC aborts the instruction.
    rand_ready = 1'b0;
    bus.opcode = 6'b000000;
    bus.mem_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    check_eq("pre_rst_exec", 32'(state), 32'd6);
    rst_n = 1'b0;
    model_cnt = 4'd0;
    #1;
    check_eq("mid_rst_state", 32'(state), 32'd0);
    check_eq("mid_rst_ctrl", 32'(obs_ctrl()), 32'(exp_ctrl(0, 1'b0, 1'b1, 1'b1)));
    check_eq("mid_rst_count", 32'(instr_count), 32'd0);
    @(negedge clk);
    check_eq("mid_rst_ctrl2", 32'(obs_ctrl()), 32'(exp_ctrl(0, 1'b0, 1'b1, 1'b1)));
    rst_n = 1'b1;
    #1;
    check_eq("post_rst_fetch", 32'(obs_ctrl()), 32'(exp_ctrl(0, 1'b0, 1'b1, 1'b0)));

    // Sixteen retirements bring a 4-bit counter back to its start value.
    rand_ready = 1'b1;
    run_instr(6'b000100, 1'b0, cyc);
    start_cnt = model_cnt;
    for (int k = 0; k < 16; k++) run_instr(6'b001000, 1'b0, cyc);
    check_eq("wrap", 32'(instr_count), 32'(start_cnt));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
